scan_letter_fifo: RTL and testbench
===================================

SCAN_LETTER_FIFO -- requirements
Module: scan_letter_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: letter FIFO entries; power of 2, 2..16.
REQ-002 SHALL have parameter EMIT_ON_BREAK, default 1: 1 = emit a letter on key release (F0 xx), 0 = emit on key press.
REQ-003 SHALL have parameter SUPPRESS_REPEAT, default 1: 1 = drop typematic repeat make codes while the key is held (EMIT_ON_BREAK=0 only).
REQ-004 CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle.
REQ-007 scan_code  in  8  PS/2 set-2 byte.
REQ-008 letter_ready  in  1  consumer accepts the head letter this cycle.
REQ-009 letter_valid  out  1  FIFO non-empty.
REQ-010 letter  out  26  one-hot head letter (bit0=A .. bit25=Z); all zeros when empty.
REQ-011 fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  out  1  sticky: a letter was dropped because the FIFO was full.
REQ-013 last_code  out  16  {previous byte, latest byte} for the HEX displays.

Function
REQ-014 Parser FSM states SHALL be IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen), and it SHALL advance only on scan_valid.
REQ-015 IDLE: F0->BRK, E0->EXT, letter code->make event, other byte->IDLE; BRK: any byte->IDLE, break event if letter; EXT: F0->EXT_BRK, else->IDLE; EXT_BRK: any->IDLE.
REQ-016 Extended (E0-prefixed) codes SHALL never produce a letter.
REQ-017 The 26 letter codes SHALL be A=1C B=32 C=21 D=23 E=24 F=2B G=34 H=33 I=43 J=3B K=42 L=4B M=3A N=31 O=44 P=4D Q=15 R=2D S=1B T=2C U=3C V=2A W=1D X=22 Y=35 Z=1A.
REQ-018 A letter SHALL be pushed for break events when EMIT_ON_BREAK=1, for make events when EMIT_ON_BREAK=0; the other event kind SHALL be ignored.
REQ-019 With EMIT_ON_BREAK=0 and SUPPRESS_REPEAT=1, a held-key register SHALL block a make equal to the held code; a break of that code SHALL clear it; a different letter's make SHALL replace it.
REQ-020 Latency: the final byte's scan_valid in cycle N SHALL give letter_valid=1 in cycle N+1 when the FIFO was empty.
REQ-021 The FIFO SHALL store 5-bit indices 0..25; letter SHALL be decoded combinationally from the head entry.
REQ-022 A pop SHALL occur when letter_valid && letter_ready; letter_ready while empty SHALL have no effect.
REQ-023 A push while full with no pop SHALL be dropped and SHALL set overflow; a push while full with a same-cycle pop SHALL be accepted, fill unchanged.
REQ-024 A simultaneous push and pop on a non-empty FIFO SHALL leave fill unchanged; pointers SHALL wrap modulo DEPTH.
REQ-025 last_code SHALL shift on every scan_valid: [15:8] gets the old [7:0], [7:0] gets scan_code.

Reset
REQ-026 reset SHALL put the FSM in IDLE, clear held key, pointers, fill, overflow and last_code; letter_valid=0, letter=0 the next cycle.
REQ-027 reset mid-sequence (e.g. after F0) SHALL discard the partial sequence; inputs in the reset cycle SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the parser state enum, the F0/E0 constants, the code-to-index table and the index-to-one-hot function.
REQ-029 The FIFO SHALL be a sub-module letter_fifo parametrised by DEPTH and WIDTH=5.

Verification
REQ-030 EMIT_ON_BREAK=1: bytes 1C, F0, 1C -> one push after the third byte; letter=26'h1, fill=1.
REQ-031 EMIT_ON_BREAK=0, SUPPRESS_REPEAT=1: 2D, 2D, 2D, F0, 2D, 2D -> exactly two pushes, letter=26'h20000 each.
REQ-032 Bytes E0, 1C, E0, F0, 1C -> no push; fill stays 0; last_code=16'hF01C.
REQ-033 DEPTH=4, letter_ready=0, five letters A..E -> fill=4, overflow=1, pops return A,B,C,D, then letter_valid=0.
REQ-034 Full FIFO with letter_ready=1 in the same cycle as a push of Z -> fill stays 4, overflow stays 0, Z is the last entry popped.
REQ-035 reset asserted after F0, then 1C -> no push; fill=0, FSM in IDLE.

Source files
------------

// File: rtl/scan_letter_fifo_pkg.sv
// Shared definitions for the PS/2 set-2 letter parser: parser states, prefix
// bytes, the scan-code-to-letter table and the index-to-one-hot decoder.
package scan_letter_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } parse_state_e;

  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam int         NUM_LETTERS = 26;
  localparam int         IDX_W       = 5;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } letter_lookup_t;

  // Entry i is the make code of letter 'A'+i.
  localparam logic [7:0] LETTER_CODES [NUM_LETTERS] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  function automatic letter_lookup_t code_to_letter(input logic [7:0] code);
    letter_lookup_t res;
    res = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (code == LETTER_CODES[i]) begin
        res.hit = 1'b1;
        res.idx = IDX_W'(i);
      end
    end
    return res;
  endfunction

  function automatic logic [NUM_LETTERS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_LETTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/scan_letter_fifo_letter_fifo.sv
// Circular FIFO with occupancy count and a sticky overflow flag; a push into a
// full FIFO is still accepted when the head is popped in the same cycle.
module letter_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     overflow_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0] fill_q;
  logic              overflow_q;
  logic              full, do_pop, do_push;

  always_comb begin
    full    = (fill_q == FILL_W'(DEPTH));
    do_pop  = (fill_q != '0) && ready_i;
    do_push = push_i && (!full || do_pop);
  end

  // NOTE: storage has no reset; fill_q gates every read, so stale entries are never visible.
  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fill_q <= fill_q + FILL_W'(do_push) - FILL_W'(do_pop);
      if (push_i && full && !do_pop) overflow_q <= 1'b1;
    end
  end

  assign valid_o    = (fill_q != '0);
  assign data_o     = mem_q[rd_ptr_q];
  assign fill_o     = fill_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/scan_letter_fifo.sv
// PS/2 set-2 byte parser that turns letter key events into one-hot letters
// queued in a small FIFO for a downstream consumer.
module scan_letter_fifo
  import scan_letter_fifo_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int EMIT_ON_BREAK   = 1,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   scan_valid,
  input  logic [7:0]             scan_code,
  input  logic                   letter_ready,
  output logic                   letter_valid,
  output logic [25:0]            letter,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
  output logic [15:0]            last_code
);

  parse_state_e     state_q;
  logic             held_valid_q;
  logic [IDX_W-1:0] held_idx_q;
  logic [15:0]      last_code_q;

  letter_lookup_t   lookup;
  logic             make_ev, break_ev, repeat_blk, push;
  logic [IDX_W-1:0] head_idx;

  always_comb begin
    lookup     = code_to_letter(scan_code);
    make_ev    = scan_valid && (state_q == ST_IDLE) && lookup.hit;
    break_ev   = scan_valid && (state_q == ST_BRK)  && lookup.hit;
    repeat_blk = (SUPPRESS_REPEAT != 0) && held_valid_q && (held_idx_q == lookup.idx);
    if (EMIT_ON_BREAK != 0) push = break_ev;
    else                    push = make_ev && !repeat_blk;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      held_valid_q <= 1'b0;
      held_idx_q   <= '0;
      last_code_q  <= '0;
    end else if (scan_valid) begin
      last_code_q <= {last_code_q[7:0], scan_code};
      case (state_q)
        ST_IDLE: begin
          if      (scan_code == CODE_BRK) state_q <= ST_BRK;
          else if (scan_code == CODE_EXT) state_q <= ST_EXT;
          else                            state_q <= ST_IDLE;
        end
        ST_EXT:  state_q <= (scan_code == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      // The held key tracks the most recent letter still physically down.
      if (make_ev) begin
        held_valid_q <= 1'b1;
        held_idx_q   <= lookup.idx;
      end else if (break_ev && held_valid_q && (held_idx_q == lookup.idx)) begin
        held_valid_q <= 1'b0;
      end
    end
  end

  letter_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .push_i     (push),
    .data_i     (lookup.idx),
    .ready_i    (letter_ready),
    .valid_o    (letter_valid),
    .data_o     (head_idx),
    .fill_o     (fill),
    .overflow_o (overflow)
  );

  assign letter    = letter_valid ? idx_to_onehot(head_idx) : '0;
  assign last_code = last_code_q;

endmodule

// File: tb/tb_scan_letter_fifo.sv
// Directed bench: one instance emitting on key release, one emitting on key
// press with repeat suppression, both fed the same byte stream.
module tb_scan_letter_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_valid;
  logic [7:0]  scan_code;
  logic        letter_ready;

  logic        b_valid, m_valid;
  logic [25:0] b_letter, m_letter;
  logic [2:0]  b_fill, m_fill;
  logic        b_ovf, m_ovf;
  logic [15:0] b_last, m_last;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  scan_letter_fifo #(.DEPTH(4), .EMIT_ON_BREAK(1), .SUPPRESS_REPEAT(1)) dut_b (
    .CLOCK_50     (clk),
    .reset        (reset),
    .scan_valid   (scan_valid),
    .scan_code    (scan_code),
    .letter_ready (letter_ready),
    .letter_valid (b_valid),
    .letter       (b_letter),
    .fill         (b_fill),
    .overflow     (b_ovf),
    .last_code    (b_last)
  );

  scan_letter_fifo #(.DEPTH(4), .EMIT_ON_BREAK(0), .SUPPRESS_REPEAT(1)) dut_m (
    .CLOCK_50     (clk),
    .reset        (reset),
    .scan_valid   (scan_valid),
    .scan_code    (scan_code),
    .letter_ready (letter_ready),
    .letter_valid (m_valid),
    .letter       (m_letter),
    .fill         (m_fill),
    .overflow     (m_ovf),
    .last_code    (m_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic apply_reset();
    reset        = 1'b1;
    scan_valid   = 1'b0;
    letter_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] code);
    scan_valid = 1'b1;
    scan_code  = code;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic pop_b(input string tag, input logic [25:0] exp);
    check({tag, "_valid"}, 32'(b_valid), 32'd1);
    check({tag, "_letter"}, 32'(b_letter), 32'(exp));
    letter_ready = 1'b1;
    @(negedge clk);
    letter_ready = 1'b0;
  endtask

  task automatic pop_m(input string tag, input logic [25:0] exp);
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_letter"}, 32'(m_letter), 32'(exp));
    letter_ready = 1'b1;
    @(negedge clk);
    letter_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  codes [5];
    logic [25:0] onehots [5];
    codes   = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    onehots = '{26'h1, 26'h2, 26'h4, 26'h8, 26'h10};

    reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; letter_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(b_valid), 32'd0);
    check("rst_letter", 32'(b_letter), 32'd0);
    check("rst_fill", 32'(b_fill), 32'd0);
    check("rst_ovf", 32'(b_ovf), 32'd0);
    check("rst_last", 32'(b_last), 32'd0);

    // Press and release of A
    send(8'h1C);
    check("a_make_b_fill", 32'(b_fill), 32'd0);
    check("a_make_m_fill", 32'(m_fill), 32'd1);
    check("a_make_m_letter", 32'(m_letter), 32'h1);
    send(8'hF0);
    check("a_f0_b_fill", 32'(b_fill), 32'd0);
    send(8'h1C);
    check("a_brk_b_valid", 32'(b_valid), 32'd1);
    check("a_brk_b_letter", 32'(b_letter), 32'h1);
    check("a_brk_b_fill", 32'(b_fill), 32'd1);
    check("a_brk_m_fill", 32'(m_fill), 32'd1);
    check("a_last", 32'(b_last), 32'hF01C);

    // Typematic repeat of R with suppression
    apply_reset();
    send(8'h2D);
    check("r1_m_fill", 32'(m_fill), 32'd1);
    send(8'h2D);
    send(8'h2D);
    check("r_rep_m_fill", 32'(m_fill), 32'd1);
    send(8'hF0);
    send(8'h2D);
    check("r_brk_m_fill", 32'(m_fill), 32'd1);
    check("r_brk_b_fill", 32'(b_fill), 32'd1);
    send(8'h2D);
    check("r2_m_fill", 32'(m_fill), 32'd2);
    check("r2_b_fill", 32'(b_fill), 32'd1);
    check("r_b_letter", 32'(b_letter), 32'h20000);
    pop_m("r_pop1", 26'h20000);
    check("r_pop1_m_fill", 32'(m_fill), 32'd1);
    pop_m("r_pop2", 26'h20000);
    check("r_end_m_valid", 32'(m_valid), 32'd0);
    check("r_end_b_valid", 32'(b_valid), 32'd0);

    // Extended codes never produce a letter
    apply_reset();
    send(8'hE0);
    send(8'h1C);
    check("ext_last1", 32'(b_last), 32'hE01C);
    send(8'hE0);
    send(8'hF0);
    send(8'h1C);
    check("ext_b_fill", 32'(b_fill), 32'd0);
    check("ext_m_fill", 32'(m_fill), 32'd0);
    check("ext_last2", 32'(m_last), 32'hF01C);

    // Overflow: five releases into a depth-4 FIFO
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'hF0);
      send(codes[i]);
    end
    check("ovf_fill", 32'(b_fill), 32'd4);
    check("ovf_flag", 32'(b_ovf), 32'd1);
    check("ovf_m_fill", 32'(m_fill), 32'd0);
    for (int i = 0; i < 4; i++) pop_b("ovf_pop", onehots[i]);
    check("ovf_empty_valid", 32'(b_valid), 32'd0);
    check("ovf_empty_letter", 32'(b_letter), 32'd0);
    letter_ready = 1'b1;
    @(negedge clk);
    letter_ready = 1'b0;
    check("empty_pop_fill", 32'(b_fill), 32'd0);
    check("ovf_sticky", 32'(b_ovf), 32'd1);

    // Push into a full FIFO with a same-cycle pop
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send(8'hF0);
      send(codes[i]);
    end
    check("full_fill", 32'(b_fill), 32'd4);
    send(8'hF0);
    check("full_head", 32'(b_letter), 32'h1);
    scan_valid = 1'b1; scan_code = 8'h1A; letter_ready = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; letter_ready = 1'b0;
    check("pp_fill", 32'(b_fill), 32'd4);
    check("pp_ovf", 32'(b_ovf), 32'd0);
    pop_b("pp_pop_b", 26'h2);
    pop_b("pp_pop_c", 26'h4);
    pop_b("pp_pop_d", 26'h8);
    pop_b("pp_pop_z", 26'h2000000);
    check("pp_empty", 32'(b_valid), 32'd0);

    // Reset in the middle of a break sequence
    apply_reset();
    send(8'hF0);
    reset = 1'b1; scan_valid = 1'b1; scan_code = 8'h1C;
    @(negedge clk);
    reset = 1'b0; scan_valid = 1'b0;
    check("mid_rst_fill", 32'(b_fill), 32'd0);
    check("mid_rst_last", 32'(b_last), 32'd0);
    send(8'h1C);
    check("mid_b_fill", 32'(b_fill), 32'd0);
    check("mid_last", 32'(b_last), 32'h001C);
    check("mid_m_fill", 32'(m_fill), 32'd1);
    send(8'hF0);
    send(8'h1C);
    check("mid_idle_fill", 32'(b_fill), 32'd1);
    check("mid_idle_letter", 32'(b_letter), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
